serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk_in, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n_in, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start_in, input, 1 bit, request to begin one addition.
REQ-005 The block SHALL have port a_in, input, WIDTH bits, operand A.
REQ-006 The block SHALL have port b_in, input, WIDTH bits, operand B.
REQ-007 The block SHALL have port c_in, input, 1 bit, carry-in for the addition.
REQ-008 The block SHALL have port busy_out, output, 1 bit, high while bits are being shifted.
REQ-009 The block SHALL have port done_out, output, 1 bit, one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum_out, output, WIDTH bits, registered result A+B+c_in mod 2^WIDTH.
REQ-011 The block SHALL have port carry_out, output, 1 bit, registered carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 Accept: at a rising edge with start_in=1 and state IDLE or DONE, the block SHALL capture a_in, b_in, c_in into internal shift/carry registers, clear the bit counter, and enter SHIFT.
REQ-014 start_in in SHIFT SHALL be ignored; operand inputs SHALL be sampled only on the accept edge.
REQ-015 In SHIFT, each edge SHALL add the current LSBs of A and B with the stored carry (one full-adder bit), shift the sum bit into the partial-sum register at the MSB end, shift A and B right by one, and store the new carry.
REQ-016 After exactly WIDTH SHIFT edges (counter reaching WIDTH-1 and incrementing), the block SHALL load sum_out and carry_out from the partial-sum and carry registers and enter DONE.
REQ-017 Latency: with accept at edge E0, sum_out/carry_out SHALL update at edge E(WIDTH) and done_out SHALL be high for exactly the one cycle following E(WIDTH).
REQ-018 busy_out SHALL be high exactly in SHIFT (WIDTH cycles per operation), low in IDLE and DONE.
REQ-019 DONE SHALL last one cycle: next state SHIFT if start_in=1 (back-to-back accept, no idle bubble), else IDLE.
REQ-020 sum_out and carry_out SHALL hold their last result unchanged through IDLE and through any subsequent SHIFT until the next E(WIDTH) edge.
REQ-021 Overflow SHALL wrap: sum_out = (A+B+c_in) mod 2^WIDTH, carry_out = bit WIDTH of the full sum.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap during an operation.

Reset
REQ-023 Assertion of rst_n_in SHALL immediately, without clock, force state IDLE, busy_out=0, done_out=0, sum_out=0, carry_out=0, and clear all internal shift, carry and counter registers.
REQ-024 Reset asserted mid-operation SHALL abort it; no done_out pulse for the aborted operation SHALL ever appear.
REQ-025 After rst_n_in deasserts, the first accept SHALL occur no earlier than the first rising edge with rst_n_in=1.

Verification (WIDTH=8)
REQ-026 A=0x0F, B=0x01, c_in=0, start one cycle -> busy_out high 8 cycles, done_out pulse in cycle 9 after accept, sum_out=0x10, carry_out=0.
REQ-027 A=0xFF, B=0x01, c_in=0 -> sum_out=0x00, carry_out=1; A=0xFF, B=0xFF, c_in=1 -> sum_out=0xFF, carry_out=1.
REQ-028 Accept A=0x12, B=0x34; pulse start_in with A=0xAA, B=0x55 during SHIFT -> result 0x46, carry 0; second request discarded, exactly one done_out.
REQ-029 start_in held high continuously with A=0x01, B=0x01, c_in=0 -> done_out every 9th cycle, busy_out low only in DONE cycles, sum_out=0x02 each time.
REQ-030 Assert rst_n_in after 4 SHIFT cycles -> all outputs 0 immediately, state IDLE, no done_out; subsequent A=0x80, B=0x80, c_in=0 -> sum_out=0x00, carry_out=1.
REQ-031 Randomized: 1000 random A, B, c_in with random start gaps -> every done_out result matches the reference sum and carry.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands plus carry-in, adds one bit per
// clock (LSB first), then presents a registered sum/carry with a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, psum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last_bit, sum_bit, carry_nxt;

    always_comb begin
        accept    = start_in && (state == IDLE || state == DONE);
        last_bit  = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
        sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start_in ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_out = (state == SHIFT);
    assign done_out = (state == DONE);

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at position 0.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_sr      <= '0;
            b_sr      <= '0;
            psum      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            psum  <= {sum_bit, psum[WIDTH-1:1]};
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= carry_nxt;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                sum_out   <= {sum_bit, psum[WIDTH-1:1]};
                carry_out <= carry_nxt;
            end
        end
    end

endmodule
